// File: rtl/ni_packetizer.sv
// Network-interface transmitter: turns (dst, len) requests plus payload words
// into head/body/tail flits for the router local port, gated by link credits.
module ni_packetizer #(
  parameter logic [2:0] LOCAL_ADD = 3'b000,
  parameter int         DATA_W    = 14,
  parameter int         MAX_LEN   = 8,
  parameter int         CREDITS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              req_valid,
  input  logic [2:0]        req_dst,
  input  logic [3:0]        req_len,
  output logic              req_ready,
  input  logic              dat_valid,
  input  logic [DATA_W-1:0] dat,
  output logic              dat_ready,
  output logic [DATA_W+1:0] flit_out,
  output logic              flit_valid,
  input  logic              credit_in,
  output logic              busy,
  output logic              err
);

  localparam int CW = $clog2(CREDITS + 1);

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  typedef struct packed {
    logic [2:0] dst;
    logic [3:0] len;
  } req_t;

  state_t            state_q, state_d;
  req_t              req_q;
  logic [3:0]        rem_q;
  logic [CW-1:0]     credit_q;
  logic              has_credit;
  logic              req_fire, len_bad;
  logic              head_send, body_send, send;
  logic [DATA_W+1:0] head_flit, body_flit;

  assign has_credit = (credit_q != '0);
  assign len_bad    = (req_len > 4'(MAX_LEN));
  // rst gates req_ready so nothing is accepted on a reset edge
  assign req_ready  = (state_q == IDLE) && en && !rst;
  assign dat_ready  = (state_q == BODY) && en && has_credit;
  assign req_fire   = req_valid && req_ready;
  assign send       = head_send || body_send;
  assign busy       = (state_q != IDLE);
  // last payload word of the packet is typed tail
  assign body_flit  = {(rem_q == 4'd1) ? 2'b10 : 2'b00, dat};

  // Head flit: dst, src, len fields; len=0 probes use the single type
  always_comb begin
    head_flit                   = '0;
    head_flit[DATA_W+1:DATA_W]  = (req_q.len == 4'd0) ? 2'b11 : 2'b01;
    head_flit[DATA_W-1 -: 3]    = req_q.dst;
    head_flit[DATA_W-4 -: 3]    = LOCAL_ADD;
    head_flit[3:0]              = req_q.len;
  end

  // Next-state and send decisions
  always_comb begin
    state_d   = state_q;
    head_send = 1'b0;
    body_send = 1'b0;
    case (state_q)
      IDLE: if (req_fire && !len_bad) state_d = HEAD;
      HEAD: if (en && has_credit) begin
        head_send = 1'b1;
        state_d   = (req_q.len == 4'd0) ? IDLE : BODY;
      end
      BODY: if (dat_valid && dat_ready) begin
        body_send = 1'b1;
        if (rem_q == 4'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request latch, flit register and error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= '0;
      rem_q      <= '0;
      flit_out   <= '0;
      flit_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      flit_valid <= send;
      // an oversized request completes its handshake but only flags err
      err        <= req_fire && len_bad;
      if (req_fire) req_q <= '{dst: req_dst, len: req_len};
      if (head_send) begin
        flit_out <= head_flit;
        rem_q    <= req_q.len;
      end else if (body_send) begin
        flit_out <= body_flit;
        rem_q    <= rem_q - 4'd1;
      end
    end
  end

  // Credit counter: one per flit sent, one back per credit_in, saturating
  always_ff @(posedge clk) begin
    if (rst)
      credit_q <= CW'(CREDITS);
    else if (send && !credit_in)
      credit_q <= credit_q - CW'(1);
    else if (!send && credit_in && credit_q != CW'(CREDITS))
      credit_q <= credit_q + CW'(1);
  end

endmodule
